// File: rtl/csa_pkg.sv
// ---------------------------------------------------------------------------
// csa_pkg
// Shared definitions for the nine-operand carry-save adder and its serial
// operand loader.
//   WIDTH      : operand and sum width (fixed to the adder width)
//   NUM_OPS    : operands per batch (fixed to the adder input count)
//   LAST_SLOT  : load_count value at which the final operand is accepted
//   state_e    : loader FSM states
//   csa_pair_t : sum/carry vectors produced by one 3:2 compressor row
//   csa3()     : one 3:2 compressor row, carry already shifted into place
// ---------------------------------------------------------------------------
package csa_pkg;

    localparam int WIDTH   = 23;
    localparam int NUM_OPS = 9;

    localparam logic [3:0] LAST_SLOT = 4'(NUM_OPS - 1);

    typedef enum logic [1:0] {
        LOAD = 2'd0,
        CALC = 2'd1,
        HOLD = 2'd2
    } state_e;

    typedef struct packed {
        logic [WIDTH-1:0] sum;
        logic [WIDTH-1:0] carry;
    } csa_pair_t;

    // The carry vector is shifted left by one inside WIDTH bits, so the
    // carry out of the top bit is dropped and the arithmetic stays modulo
    // 2^WIDTH all the way through the tree.
    function automatic csa_pair_t csa3(
        input logic [WIDTH-1:0] a,
        input logic [WIDTH-1:0] b,
        input logic [WIDTH-1:0] c
    );
        csa_pair_t r;
        r.sum   = a ^ b ^ c;
        r.carry = ((a & b) | (a & c) | (b & c)) << 1;
        return r;
    endfunction

endpackage

// File: rtl/carry_save_adder.sv
// ---------------------------------------------------------------------------
// carry_save_adder
// Purely combinational nine-input adder. A Wallace-style tree of 3:2
// compressors reduces nine operands to two, and a single carry-propagate
// add produces the final result.
//   I0..I8 : input  [WIDTH-1:0]  operands
//   out    : output [WIDTH-1:0]  sum of I0..I8 modulo 2^WIDTH
// ---------------------------------------------------------------------------
module carry_save_adder
    import csa_pkg::*;
(
    input  logic [WIDTH-1:0] I0,
    input  logic [WIDTH-1:0] I1,
    input  logic [WIDTH-1:0] I2,
    input  logic [WIDTH-1:0] I3,
    input  logic [WIDTH-1:0] I4,
    input  logic [WIDTH-1:0] I5,
    input  logic [WIDTH-1:0] I6,
    input  logic [WIDTH-1:0] I7,
    input  logic [WIDTH-1:0] I8,
    output logic [WIDTH-1:0] out
);

    csa_pair_t l1a, l1b, l1c;
    csa_pair_t l2a, l2b;
    csa_pair_t l3;
    csa_pair_t l4;

    // Reduction 9 -> 6 -> 4 -> 3 -> 2, then one carry-propagate add.
    always_comb begin
        l1a = csa3(I0, I1, I2);
        l1b = csa3(I3, I4, I5);
        l1c = csa3(I6, I7, I8);

        l2a = csa3(l1a.sum, l1a.carry, l1b.sum);
        l2b = csa3(l1b.carry, l1c.sum, l1c.carry);

        l3  = csa3(l2a.sum, l2a.carry, l2b.sum);

        l4  = csa3(l3.sum, l3.carry, l2b.carry);

        out = l4.sum + l4.carry;
    end

endmodule

// File: rtl/nine_operand_loader.sv
// ---------------------------------------------------------------------------
// nine_operand_loader
// Collects nine operands over a valid/ready stream into an operand bank
// that feeds the carry_save_adder, registers the adder result and presents
// it on a valid/ready output handshake.
//   clk        : input         rising-edge clock
//   rst_n      : input         asynchronous active-low reset
//   in_valid   : input         in_data holds an operand
//   in_ready   : output        an operand can be accepted this cycle
//   in_data    : input  [22:0] operand word
//   flush      : input         discard a partially loaded batch
//   load_count : output [3:0]  operands accepted in the current batch
//   sum_valid  : output        sum_data holds a result
//   sum_ready  : input         consumer accepts the result
//   sum_data   : output [22:0] nine-way sum modulo 2^23
// ---------------------------------------------------------------------------
module nine_operand_loader
    import csa_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             flush,
    output logic [3:0]       load_count,
    output logic             sum_valid,
    input  logic             sum_ready,
    output logic [WIDTH-1:0] sum_data
);

    state_e           state_q, state_d;
    logic [3:0]       count_q, count_d;
    logic [WIDTH-1:0] slot_q [NUM_OPS];
    logic [WIDTH-1:0] sum_q;
    logic [WIDTH-1:0] adder_out;
    logic             accept;

    // Both handshake outputs are decoded from the state register only, so
    // neither has a combinational path from in_valid or sum_ready.
    assign in_ready   = (state_q == LOAD);
    assign sum_valid  = (state_q == HOLD);
    assign load_count = count_q;
    assign sum_data   = sum_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= LOAD;
            count_q <= 4'd0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
        end
    end

    // Flush takes priority over an accept in the same cycle, so a word that
    // arrives together with flush (even the ninth) is dropped.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        accept  = 1'b0;
        unique case (state_q)
            LOAD: begin
                if (flush) begin
                    count_d = 4'd0;
                end else if (in_valid) begin
                    accept  = 1'b1;
                    count_d = count_q + 4'd1;
                    if (count_q == LAST_SLOT) begin
                        state_d = CALC;
                    end
                end
            end
            CALC: begin
                state_d = HOLD;
            end
            HOLD: begin
                if (sum_ready) begin
                    state_d = LOAD;
                    count_d = 4'd0;
                end
            end
            default: begin
                state_d = LOAD;
                count_d = 4'd0;
            end
        endcase
    end

    // The k-th accepted word lands in slot k, which drives adder input Ik.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_OPS; i++) begin
                slot_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_OPS; i++) begin
                if (accept && (count_q == 4'(i))) begin
                    slot_q[i] <= in_data;
                end
            end
        end
    end

    // The result is captured at the end of CALC and then held, including
    // after the output handshake, until the next batch completes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q <= '0;
        end else if (state_q == CALC) begin
            sum_q <= adder_out;
        end
    end

    carry_save_adder u_adder (
        .I0  (slot_q[0]),
        .I1  (slot_q[1]),
        .I2  (slot_q[2]),
        .I3  (slot_q[3]),
        .I4  (slot_q[4]),
        .I5  (slot_q[5]),
        .I6  (slot_q[6]),
        .I7  (slot_q[7]),
        .I8  (slot_q[8]),
        .out (adder_out)
    );

endmodule

// File: tb/tb_nine_operand_loader.sv
// ---------------------------------------------------------------------------
// tb_nine_operand_loader
// Directed self-checking bench for nine_operand_loader. Inputs are driven on
// the falling edge and outputs are sampled 1ns after the rising edge.
// ---------------------------------------------------------------------------
module tb_nine_operand_loader;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [22:0] in_data;
    logic        flush;
    logic [3:0]  load_count;
    logic        sum_valid;
    logic        sum_ready;
    logic [22:0] sum_data;

    int testsRun  = 0;
    int failCount = 0;

    nine_operand_loader dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .flush      (flush),
        .load_count (load_count),
        .sum_valid  (sum_valid),
        .sum_ready  (sum_ready),
        .sum_data   (sum_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One comparison: counts it, and reports tag/observed/expected on a miss.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        testsRun++;
        assert (observed === expected)
        else begin
            failCount++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Presents one word (optionally with flush) for exactly one rising edge.
    task automatic applyStimulus(input logic [22:0] data, input logic doFlush);
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = data;
        flush    = doFlush;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        flush    = 1'b0;
    endtask

    // Waits a bounded number of cycles for sum_valid; an expiry is a failure.
    task automatic waitForSum(input string tag, input int budget);
        int n = 0;
        while (!sum_valid && n < budget) begin
            @(posedge clk);
            #1;
            n++;
        end
        checkOutput(tag, {31'd0, sum_valid}, 32'd1);
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        flush     = 1'b0;
        sum_ready = 1'b1;

        // Reset state
        #12;
        checkOutput("rst in_ready",   {31'd0, in_ready},   32'd1);
        checkOutput("rst sum_valid",  {31'd0, sum_valid},  32'd0);
        checkOutput("rst sum_data",   {9'd0, sum_data},    32'd0);
        checkOutput("rst load_count", {28'd0, load_count}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Basic sum: 1..9 back-to-back, exact latency
        for (int i = 1; i <= 9; i++) begin
            applyStimulus(23'(i), 1'b0);
            if (i == 4) checkOutput("basic count4", {28'd0, load_count}, 32'd4);
        end
        checkOutput("basic count9",      {28'd0, load_count}, 32'd9);
        checkOutput("basic calc ready",  {31'd0, in_ready},   32'd0);
        checkOutput("basic calc valid",  {31'd0, sum_valid},  32'd0);
        @(posedge clk); #1;
        checkOutput("basic hold valid",  {31'd0, sum_valid},  32'd1);
        checkOutput("basic sum",         {9'd0, sum_data},    32'd45);
        checkOutput("basic hold ready",  {31'd0, in_ready},   32'd0);
        @(posedge clk); #1;
        checkOutput("basic post valid",  {31'd0, sum_valid},  32'd0);
        checkOutput("basic post ready",  {31'd0, in_ready},   32'd1);
        checkOutput("basic post count",  {28'd0, load_count}, 32'd0);
        checkOutput("basic post data",   {9'd0, sum_data},    32'd45);

        // Wrap: nine words of 0x7FFFFF
        for (int i = 0; i < 9; i++) applyStimulus(23'h7FFFFF, 1'b0);
        waitForSum("wrap timeout", 4);
        checkOutput("wrap sum", {9'd0, sum_data}, 32'h7FFFF7);
        @(posedge clk); #1;

        // Backpressure: nine 3s, hold for 5 cycles with in_valid asserted
        sum_ready = 1'b0;
        for (int i = 0; i < 9; i++) applyStimulus(23'd3, 1'b0);
        waitForSum("bp timeout", 4);
        in_valid = 1'b1;
        in_data  = 23'd77;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            checkOutput("bp valid", {31'd0, sum_valid},  32'd1);
            checkOutput("bp data",  {9'd0, sum_data},    32'd27);
            checkOutput("bp ready", {31'd0, in_ready},   32'd0);
            checkOutput("bp count", {28'd0, load_count}, 32'd9);
        end
        @(negedge clk);
        in_valid  = 1'b0;
        sum_ready = 1'b1;
        @(posedge clk); #1;
        checkOutput("bp post count", {28'd0, load_count}, 32'd0);
        checkOutput("bp post valid", {31'd0, sum_valid},  32'd0);
        checkOutput("bp post ready", {31'd0, in_ready},   32'd1);
        checkOutput("bp post data",  {9'd0, sum_data},    32'd27);

        // Flush mid-batch: four 100s, flush alone, then 1..9
        for (int i = 0; i < 4; i++) applyStimulus(23'd100, 1'b0);
        checkOutput("flush pre count", {28'd0, load_count}, 32'd4);
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        checkOutput("flush count", {28'd0, load_count}, 32'd0);
        for (int i = 1; i <= 9; i++) applyStimulus(23'(i), 1'b0);
        waitForSum("flush timeout", 4);
        checkOutput("flush sum", {9'd0, sum_data}, 32'd45);
        @(posedge clk); #1;

        // Flush together with the 9th word: no CALC
        for (int i = 0; i < 8; i++) applyStimulus(23'd5, 1'b0);
        checkOutput("f9 pre count", {28'd0, load_count}, 32'd8);
        applyStimulus(23'd5, 1'b1);
        checkOutput("f9 count", {28'd0, load_count}, 32'd0);
        checkOutput("f9 ready", {31'd0, in_ready},   32'd1);
        @(posedge clk); #1;
        checkOutput("f9 no valid", {31'd0, sum_valid}, 32'd0);

        // Nine 2s with idle gaps after the 4th word
        for (int i = 0; i < 9; i++) begin
            applyStimulus(23'd2, 1'b0);
            if (i == 3) begin
                repeat (2) @(posedge clk);
                #1;
                checkOutput("gap count", {28'd0, load_count}, 32'd4);
            end
        end
        waitForSum("twos timeout", 4);
        checkOutput("twos sum", {9'd0, sum_data}, 32'd18);
        @(posedge clk); #1;

        // Reset while in HOLD with sum_data=45
        sum_ready = 1'b0;
        for (int i = 1; i <= 9; i++) applyStimulus(23'(i), 1'b0);
        waitForSum("rsthold timeout", 4);
        checkOutput("rsthold sum", {9'd0, sum_data}, 32'd45);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkOutput("midrst valid", {31'd0, sum_valid},  32'd0);
        checkOutput("midrst data",  {9'd0, sum_data},    32'd0);
        checkOutput("midrst count", {28'd0, load_count}, 32'd0);
        checkOutput("midrst ready", {31'd0, in_ready},   32'd1);
        @(negedge clk);
        rst_n     = 1'b1;
        sum_ready = 1'b1;
        for (int i = 1; i <= 9; i++) applyStimulus(23'(i), 1'b0);
        waitForSum("postrst timeout", 4);
        checkOutput("postrst sum", {9'd0, sum_data}, 32'd45);
        @(posedge clk); #1;
        checkOutput("postrst ready", {31'd0, in_ready}, 32'd1);

        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end

endmodule
